cache_mem_ctrl: RTL and testbench
=================================

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for mem_ready on one word access.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 1 bit: the cache miss request, held high by the cache until done or err.
REQ-005 SHALL have port wb_req, input, 1 bit: the victim line is dirty and must be written back; sampled with req.
REQ-006 SHALL have port wb_addr, input, 10 bits: any byte address inside the victim block.
REQ-007 SHALL have port fill_addr, input, 10 bits: any byte address inside the missing block.
REQ-008 SHALL have port wb_data, input, 32 bits: the cache word of the victim line selected by word_idx.
REQ-009 SHALL have port word_idx, output, 2 bits: the current word within the block.
REQ-010 SHALL have port mem_en, output, 1 bit: a memory access is in progress.
REQ-011 SHALL have port mem_we, output, 1 bit: the access is a write (1) or a read (0).
REQ-012 SHALL have port mem_addr, output, 10 bits: the word-aligned memory byte address.
REQ-013 SHALL have port mem_wdata, output, 32 bits: the memory write data.
REQ-014 SHALL have port mem_rdata, input, 32 bits: the memory read data, valid when mem_ready=1.
REQ-015 SHALL have port mem_ready, input, 1 bit: the current access completes this cycle.
REQ-016 SHALL have port fill_we, output, 1 bit: write fill_data into the cache line at word_idx.
REQ-017 SHALL have port fill_data, output, 32 bits: the refill word.
REQ-018 SHALL have port busy, output, 1 bit: the controller is not in IDLE.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse, the refill completed.
REQ-020 SHALL have port err, output, 1 bit: one-cycle pulse, a memory timeout aborted the transfer.

Function
REQ-021 SHALL implement states IDLE, WB, FILL, DONE and ERR.
REQ-022 SHALL, in IDLE with req=1, latch wb_addr[9:4] and fill_addr[9:4] and clear word_idx; it SHALL go to WB if wb_req=1, else to FILL.
REQ-023 SHALL drive mem_addr = {latched block[9:4], word_idx, 2'b00}, using the WB block in WB and the FILL block in FILL.
REQ-024 SHALL, in WB, drive mem_en=1, mem_we=1 and mem_wdata=wb_data, each held stable until mem_ready=1.
REQ-025 SHALL, in FILL, drive mem_en=1 and mem_we=0.
REQ-026 SHALL, on each mem_ready=1 in FILL, drive fill_we=1 and fill_data=mem_rdata combinationally in that same cycle.
REQ-027 SHALL increment word_idx on every mem_ready=1 in WB or FILL.
REQ-028 SHALL, on mem_ready=1 with word_idx=3, wrap word_idx to 0 and move WB to FILL, or FILL to DONE.
REQ-029 SHALL, with zero-wait memory (mem_ready tied high), assert done 5 cycles after the accept edge without write-back and 9 cycles after it with write-back.
REQ-030 SHALL assert done=1 in DONE for exactly one cycle, then go to IDLE; req is ignored in DONE.
REQ-031 SHALL keep a per-word wait counter, cleared at each word start and at each mem_ready.
REQ-032 SHALL, if the wait counter reaches TIMEOUT without mem_ready, go to ERR.
REQ-033 SHALL, in ERR, assert err=1 for one cycle with fill_we=0, then go to IDLE; done is not asserted.
REQ-034 SHALL ignore mem_ready while in IDLE, DONE or ERR.
REQ-035 SHALL drive mem_en, mem_we and fill_we to 0 in IDLE, DONE and ERR.
REQ-036 SHALL drive busy=1 in every state except IDLE.
REQ-037 SHALL drive mem_wdata to 0 outside WB and fill_data to 0 when fill_we=0.
REQ-038 SHALL let a req deasserted mid-transfer have no effect; the transfer runs to DONE or ERR.

Reset
REQ-039 SHALL, while rst_n=0, immediately force IDLE, word_idx=0, wait counter=0 and latched addresses=0.
REQ-040 SHALL, while rst_n=0, hold every output at 0.
REQ-041 SHALL treat a reset during WB or FILL as an abort: no done, no err, and no further mem_en until a new req.

Verification
REQ-042 SHALL cover a clean miss: req=1, wb_req=0, fill_addr=0x1A4, mem_ready=1 -> mem_addr 0x1A0, 0x1A4, 0x1A8, 0x1AC with mem_we=0 and fill_we each cycle; done at cycle 5.
REQ-043 SHALL cover a dirty miss: wb_addr=0x3F0, fill_addr=0x010, wb_req=1 -> writes to 0x3F0-0x3FC carrying wb_data, then reads 0x010-0x01C; done at cycle 9.
REQ-044 SHALL cover wait states: mem_ready low for 3 cycles per word -> mem_addr and mem_wdata held stable; done at cycle 17 for a clean miss.
REQ-045 SHALL cover timeout: mem_ready stuck at 0 in FILL word 2 -> err pulses after TIMEOUT cycles, done=0, fill_we pulses only for words 0 and 1, then IDLE.
REQ-046 SHALL cover reset in WB word 1: assert rst_n=0 -> all outputs 0 in the same cycle; after release, busy=0 until the next req.
REQ-047 SHALL cover req held high through DONE: exactly one done pulse, then a second transfer is accepted from IDLE on the following cycle.

Source files
------------

// File: rtl/cache_mem_ctrl.sv
// Cache miss controller: optional dirty-line write-back, then 4-word refill.
// Per-word memory wait is bounded by TIMEOUT; expiry aborts with an err pulse.
module cache_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wb_req,
  input  logic [9:0]  wb_addr,
  input  logic [9:0]  fill_addr,
  input  logic [31:0] wb_data,
  output logic [1:0]  word_idx,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        fill_we,
  output logic [31:0] fill_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WB, FILL, DONE, ERR} state_t;

  state_t          state, nxt;
  logic [1:0]      idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [5:0]      wb_blk, fill_blk;
  logic            accept;
  logic            unused;

  assign unused = ^{wb_addr[3:0], fill_addr[3:0]};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= 2'd0;
      cnt      <= '0;
      wb_blk   <= 6'd0;
      fill_blk <= 6'd0;
    end else begin
      state    <= nxt;
      word_idx <= idx_nxt;
      cnt      <= cnt_nxt;
      if (accept) begin
        wb_blk   <= wb_addr[9:4];
        fill_blk <= fill_addr[9:4];
      end
    end
  end

  always_comb begin
    nxt       = state;
    idx_nxt   = word_idx;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 10'd0;
    mem_wdata = 32'd0;
    fill_we   = 1'b0;
    fill_data = 32'd0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          nxt     = wb_req ? WB : FILL;
          idx_nxt = 2'd0;
          cnt_nxt = '0;
        end
      end
      WB: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_blk, word_idx, 2'b00};
        mem_wdata = wb_data;
      end
      FILL: begin
        mem_en   = 1'b1;
        mem_addr = {fill_blk, word_idx, 2'b00};
        if (mem_ready) begin
          fill_we   = 1'b1;
          fill_data = mem_rdata;
        end
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      ERR: begin
        err = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Shared word sequencing for WB and FILL
    if (mem_en) begin
      if (mem_ready) begin
        idx_nxt = word_idx + 2'd1;
        cnt_nxt = '0;
        if (word_idx == 2'd3)
          nxt = (state == WB) ? FILL : DONE;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        nxt     = ERR;
        idx_nxt = 2'd0;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: per-cycle plan of stimulus and expected outputs
// built from transaction descriptions, checked every cycle on the falling edge.
module tb_cache_mem_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wb_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic [9:0]  wb_addr = '0;
  logic [9:0]  fill_addr = '0;
  logic [31:0] wb_data, mem_rdata;
  logic [1:0]  word_idx;
  logic        mem_en, mem_we, fill_we, busy, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, fill_data;

  cache_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wb_req(wb_req),
    .wb_addr(wb_addr), .fill_addr(fill_addr), .wb_data(wb_data),
    .word_idx(word_idx), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .fill_we(fill_we), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wb_word(logic [1:0] j);
    return {16'hDA7A, 6'd0, j, 8'h5A};
  endfunction

  function automatic logic [31:0] mem_word(logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  assign wb_data   = wb_word(word_idx);
  assign mem_rdata = mem_word(mem_addr);

  typedef struct {
    bit          rst_n, req, wb_req, rdy, start;
    logic [9:0]  wa, fa;
    bit          busy, en, we, fwe, dn, er;
    logic [1:0]  idx;
    logic [9:0]  addr;
    logic [31:0] wdata, fdata;
  } cyc_t;

  cyc_t plan[$];
  cyc_t expq[$];
  int   nchk = 0, npass = 0;
  int   cyc = 0, done_at = -1, err_at = -1, fwe_cnt = 0, done_cnt = 0;

  function automatic cyc_t blank(bit r);
    cyc_t e;
    e = '{default: '0};
    e.rst_n = r;
    e.rdy = 1'b1;
    return e;
  endfunction

  function automatic cyc_t act(bit p, logic [1:0] j, logic [9:0] a,
                               bit rdy, bit rq, bit wb,
                               logic [9:0] wa, logic [9:0] fa);
    cyc_t e;
    e = blank(1'b1);
    e.rdy = rdy;
    e.req = rq;
    e.wb_req = ~wb;
    e.wa = ~wa;
    e.fa = ~fa;
    e.busy = 1'b1;
    e.en = 1'b1;
    e.we = !p;
    e.idx = j;
    e.addr = a;
    e.wdata = p ? 32'd0 : wb_word(j);
    e.fwe = p && rdy;
    e.fdata = e.fwe ? mem_word(a) : 32'd0;
    return e;
  endfunction

  task automatic idle(int n, bit r);
    repeat (n) plan.push_back(blank(r));
  endtask

  task automatic xfer(bit wb, logic [9:0] wa, logic [9:0] fa, int waits,
                      int stuck, int rst_word, bit hold, bit drop);
    cyc_t e;
    logic [9:0] a;
    logic [1:0] jj;
    int lows;
    e = blank(1'b1);
    e.req = 1'b1;
    e.wb_req = wb;
    e.wa = wa;
    e.fa = fa;
    e.start = 1'b1;
    plan.push_back(e);
    for (int p = (wb ? 0 : 1); p < 2; p++) begin
      for (int j = 0; j < 4; j++) begin
        jj = 2'(j);
        if (p == 0 && j == rst_word) begin
          e = blank(1'b0);
          e.req = 1'b1;
          plan.push_back(e);
          return;
        end
        a = {(p == 1) ? fa[9:4] : wa[9:4], jj, 2'b00};
        lows = (p == 1 && j == stuck) ? TO : waits;
        for (int l = 0; l < lows; l++)
          plan.push_back(act(p[0], jj, a, 1'b0, !drop, wb, wa, fa));
        if (p == 1 && j == stuck) begin
          e = blank(1'b1);
          e.req = !drop;
          e.busy = 1'b1;
          e.er = 1'b1;
          plan.push_back(e);
          return;
        end
        plan.push_back(act(p[0], jj, a, 1'b1, !drop, wb, wa, fa));
      end
    end
    e = blank(1'b1);
    e.req = hold;
    e.busy = 1'b1;
    e.dn = 1'b1;
    plan.push_back(e);
  endtask

  task automatic drain();
    cyc_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(posedge clk);
      #1;
      rst_n = e.rst_n;
      req = e.req;
      wb_req = e.wb_req;
      wb_addr = e.wa;
      fill_addr = e.fa;
      mem_ready = e.rdy;
      expq.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string n, int act_v, int exp_v);
    nchk++;
    if (act_v == exp_v) npass++;
    else $display("FAIL %s: got %0d want %0d", n, act_v, exp_v);
  endtask

  cyc_t        ce;
  logic [81:0] got, want;

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      got = {busy, mem_en, mem_we, fill_we, done, err, word_idx,
             mem_addr, mem_wdata, fill_data};
      want = {ce.busy, ce.en, ce.we, ce.fwe, ce.dn, ce.er, ce.idx,
              ce.addr, ce.wdata, ce.fdata};
      nchk++;
      if (got === want) npass++;
      else $display("FAIL cycle@%0t outputs: got %h want %h", $time, got, want);
      if (ce.start) begin
        cyc = 0;
        done_at = -1;
        err_at = -1;
        fwe_cnt = 0;
      end else begin
        cyc++;
      end
      if (done === 1'b1) begin
        done_at = cyc;
        done_cnt++;
      end
      if (err === 1'b1) err_at = cyc;
      if (fill_we === 1'b1) fwe_cnt++;
    end
  end

  initial begin
    idle(3, 1'b0);
    idle(2, 1'b1);
    drain();

    xfer(1'b0, 10'h000, 10'h1A4, 0, -1, -1, 1'b0, 1'b0);
    idle(2, 1'b1);
    chk("model_addr0", int'(plan[1].addr), 'h1A0);
    chk("model_addr3", int'(plan[4].addr), 'h1AC);
    drain();
    chk("clean_done_at", done_at, 5);
    chk("clean_fill_we", fwe_cnt, 4);

    xfer(1'b1, 10'h3F0, 10'h010, 0, -1, -1, 1'b0, 1'b0);
    idle(2, 1'b1);
    drain();
    chk("dirty_done_at", done_at, 9);
    chk("dirty_fill_we", fwe_cnt, 4);

    xfer(1'b0, 10'h0C4, 10'h2B8, 3, -1, -1, 1'b0, 1'b0);
    idle(2, 1'b1);
    drain();
    chk("wait_done_at", done_at, 17);

    xfer(1'b1, 10'h21C, 10'h3E0, 1, -1, -1, 1'b0, 1'b1);
    idle(2, 1'b1);
    drain();
    chk("drop_done_at", done_at, 17);

    xfer(1'b0, 10'h000, 10'h154, 0, 2, -1, 1'b0, 1'b0);
    idle(3, 1'b1);
    drain();
    chk("to_err_at", err_at, 18);
    chk("to_fill_we", fwe_cnt, 2);
    chk("to_done_at", done_at, -1);

    xfer(1'b1, 10'h155, 10'h2AA, 0, -1, 1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);
    drain();
    chk("rst_done_at", done_at, -1);
    chk("rst_err_at", err_at, -1);

    done_cnt = 0;
    xfer(1'b0, 10'h000, 10'h0F8, 0, -1, -1, 1'b1, 1'b0);
    xfer(1'b1, 10'h300, 10'h08C, 0, -1, -1, 1'b0, 1'b0);
    idle(2, 1'b1);
    drain();
    chk("hold_done_cnt", done_cnt, 2);
    chk("hold_done_at", done_at, 9);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
